control_transfer_sequencer: RTL and testbench

- Sequences every control-transfer instruction (JAL, JALR, conditional branch) through a shared target-computation datapath.
- Accepts one decoded transfer at a time from decode with a valid/ready handshake.
- Computes link value, target and branch condition, then issues a PC redirect to fetch.
- Holds a pipeline flush for a programmable number of cycles; flags misaligned targets.

---
 rtl/ctrl_xfer_pkg.sv | 28 ++
 rtl/branch_condition_unit.sv | 27 ++
 rtl/control_transfer_sequencer.sv | 170 +++++++++++++++++
 tb/tb_control_transfer_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_xfer_pkg.sv
// Shared encodings for the control-transfer sequencer: transfer kinds, branch
// funct3 codes, FSM states and the link offset.
package ctrl_xfer_pkg;

  typedef enum logic [1:0] {
    XFER_JAL    = 2'd0,
    XFER_JALR   = 2'd1,
    XFER_BRANCH = 2'd2,
    XFER_NOP    = 2'd3
  } xfer_kind_e;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CALC     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } seq_state_e;

  localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/branch_condition_unit.sv
// Combinational branch resolver: compares rs1/rs2 according to funct3.
// Codes 2 and 3 have no branch meaning and always resolve not-taken.
module branch_condition_unit
  import ctrl_xfer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_transfer_sequencer.sv
// Sequences JAL/JALR/branch through one target datapath, offers a redirect to
// fetch and then holds flush. Optional macro MISALIGN_TRAP_EN traps misaligned targets.
module control_transfer_sequencer
  import ctrl_xfer_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_kind,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [XLEN-1:0] immediate,
  output logic            rd_write,
  output logic [XLEN-1:0] rd_value,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            misalign,
  output logic            busy
);

  seq_state_e      state;
  xfer_kind_e      kind_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] imm_q;
  logic [3:0]      flush_count;

  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] rs1_plus_imm;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] target;
  logic            branch_taken;
  logic            transfer;
  logic            links;
  logic            trap;

  branch_condition_unit #(.XLEN(XLEN)) u_branch_condition_unit (
    .funct3 (funct3_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .taken  (branch_taken)
  );

  assign pc_plus_imm  = pc_q + imm_q;
  assign rs1_plus_imm = rs1_q + imm_q;
  assign link         = pc_q + XLEN'(LINK_OFFSET);
  assign links        = (kind_q == XFER_JAL) || (kind_q == XFER_JALR);

  always_comb begin
    target   = pc_plus_imm;
    transfer = 1'b0;
    case (kind_q)
      XFER_JAL: begin
        transfer = 1'b1;
      end
      XFER_JALR: begin
        target   = {rs1_plus_imm[XLEN-1:1], 1'b0};
        transfer = 1'b1;
      end
      XFER_BRANCH: begin
        transfer = branch_taken;
      end
      default: begin
        transfer = 1'b0;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = transfer && (target[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // op_ready is registered, so after any return to IDLE other than the end of
  // FLUSH it rises one cycle later; FLUSH hands op_ready back as flush drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      op_ready       <= 1'b0;
      busy           <= 1'b0;
      rd_write       <= 1'b0;
      rd_value       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      misalign       <= 1'b0;
      flush_count    <= 4'd0;
      kind_q         <= XFER_NOP;
      funct3_q       <= 3'd0;
      pc_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      imm_q          <= '0;
    end else begin
      rd_write <= 1'b0;
      misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid && op_ready) begin
            kind_q   <= xfer_kind_e'(op_kind);
            funct3_q <= funct3;
            pc_q     <= pc;
            rs1_q    <= rs1_value;
            rs2_q    <= rs2_value;
            imm_q    <= immediate;
            op_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_CALC;
          end else begin
            op_ready <= 1'b1;
          end
        end
        ST_CALC: begin
          if (trap) begin
            misalign <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            if (links) begin
              rd_write <= 1'b1;
              rd_value <= link;
            end
            if (transfer) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= target;
              state          <= ST_REDIRECT;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
            flush_count    <= 4'(FLUSH_CYCLES);
            state          <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_count <= 4'd1) begin
            flush_count <= 4'd0;
            flush       <= 1'b0;
            op_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            flush_count <= flush_count - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_transfer_sequencer.sv
// Self-checking bench for control_transfer_sequencer: directed vector table,
// hand-written reset sequences and random transfers against a reference model.
module tb_control_transfer_sequencer;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            op_valid;
  logic            op_ready;
  logic [1:0]      op_kind;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic [XLEN-1:0] immediate;
  logic            rd_write;
  logic [XLEN-1:0] rd_value;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            misalign;
  logic            busy;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    string       name;
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] pc_in;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    int          delay;
    bit          exp_rd_write;
    logic [31:0] exp_rd_value;
    bit          exp_redirect;
    logic [31:0] exp_redirect_pc;
    bit          exp_misalign;
  } vec_t;

  vec_t vecs[$];

  control_transfer_sequencer #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clock          (clock),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_kind        (op_kind),
    .funct3         (funct3),
    .pc             (pc),
    .rs1_value      (rs1_value),
    .rs2_value      (rs2_value),
    .immediate      (immediate),
    .rd_write       (rd_write),
    .rd_value       (rd_value),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .misalign       (misalign),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  function automatic vec_t mk(input string name, input logic [1:0] kind, input logic [2:0] f3,
                              input logic [31:0] pc_in, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] imm, input int delay, input bit erw,
                              input logic [31:0] erv, input bit ered, input logic [31:0] erpc,
                              input bit emis);
    vec_t v;
    v.name = name; v.kind = kind; v.f3 = f3; v.pc_in = pc_in; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.delay = delay; v.exp_rd_write = erw; v.exp_rd_value = erv;
    v.exp_redirect = ered; v.exp_redirect_pc = erpc; v.exp_misalign = emis;
    return v;
  endfunction

  // Reference model: instruction semantics taken straight from the ISA rules.
  function automatic vec_t ref_model(input string name, input logic [1:0] kind, input logic [2:0] f3,
                                     input logic [31:0] pc_in, input logic [31:0] rs1,
                                     input logic [31:0] rs2, input logic [31:0] imm, input int delay);
    logic [31:0] tgt;
    bit taken;
    bit is_link;
    bit trapped;
    longint s1;
    longint s2;
    s1 = longint'($signed(rs1));
    s2 = longint'($signed(rs2));
    is_link = (kind == 2'd0) || (kind == 2'd1);
    tgt = (kind == 2'd1) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc_in + imm);
    case (f3)
      3'd0: taken = (rs1 == rs2);
      3'd1: taken = (rs1 != rs2);
      3'd4: taken = (s1 < s2);
      3'd5: taken = (s1 >= s2);
      3'd6: taken = (rs1 < rs2);
      3'd7: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
    if (is_link) taken = 1'b1;
    if (kind == 2'd3) taken = 1'b0;
    trapped = TRAP && taken && (tgt[1:0] != 2'b00);
    return mk(name, kind, f3, pc_in, rs1, rs2, imm, delay, is_link && !trapped, pc_in + 32'd4,
              taken && !trapped, tgt, trapped);
  endfunction

  // Drives one transfer and follows it cycle by cycle until op_ready returns.
  task automatic applyStimulus(input vec_t v);
    int waited = 0;
    logic [31:0] held_pc;
    while (!op_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    checkOutput({v.name, " op_ready before accept"}, 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_kind = v.kind; funct3 = v.f3; pc = v.pc_in;
    rs1_value = v.rs1; rs2_value = v.rs2; immediate = v.imm;
    redirect_ready = (v.delay == 0);
    @(negedge clock);
    op_valid = 1'b0; op_kind = 2'($urandom); funct3 = 3'($urandom); pc = $urandom;
    rs1_value = $urandom; rs2_value = $urandom; immediate = $urandom;
    checkOutput({v.name, " calc op_ready"}, 32'(op_ready), 32'd0);
    checkOutput({v.name, " calc busy"}, 32'(busy), 32'd1);
    checkOutput({v.name, " calc redirect_valid"}, 32'(redirect_valid), 32'd0);
    checkOutput({v.name, " calc rd_write"}, 32'(rd_write), 32'd0);
    @(negedge clock);
    checkOutput({v.name, " rd_write"}, 32'(rd_write), 32'(v.exp_rd_write));
    if (v.exp_rd_write) checkOutput({v.name, " rd_value"}, rd_value, v.exp_rd_value);
    checkOutput({v.name, " misalign"}, 32'(misalign), 32'(v.exp_misalign));
    checkOutput({v.name, " redirect_valid"}, 32'(redirect_valid), 32'(v.exp_redirect));
    checkOutput({v.name, " op_ready after calc"}, 32'(op_ready), 32'd0);
    checkOutput({v.name, " busy after calc"}, 32'(busy), 32'(v.exp_redirect));
    if (v.exp_redirect) begin
      checkOutput({v.name, " redirect_pc"}, redirect_pc, v.exp_redirect_pc);
      held_pc = v.exp_redirect_pc;
      for (int j = 1; j <= v.delay; j++) begin
        @(negedge clock);
        checkOutput({v.name, " stall redirect_valid"}, 32'(redirect_valid), 32'd1);
        checkOutput({v.name, " stall redirect_pc"}, redirect_pc, held_pc);
        checkOutput({v.name, " stall flush"}, 32'(flush), 32'd0);
      end
      redirect_ready = 1'b1;
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
        @(negedge clock);
        redirect_ready = 1'b0;
        checkOutput({v.name, " flush"}, 32'(flush), 32'd1);
        checkOutput({v.name, " flush redirect_valid"}, 32'(redirect_valid), 32'd0);
        checkOutput({v.name, " flush op_ready"}, 32'(op_ready), 32'd0);
        checkOutput({v.name, " flush rd_write"}, 32'(rd_write), 32'd0);
      end
      @(negedge clock);
      checkOutput({v.name, " flush end"}, 32'(flush), 32'd0);
      checkOutput({v.name, " op_ready after flush"}, 32'(op_ready), 32'd1);
      checkOutput({v.name, " busy after flush"}, 32'(busy), 32'd0);
    end else begin
      @(negedge clock);
      redirect_ready = 1'b0;
      checkOutput({v.name, " op_ready return"}, 32'(op_ready), 32'd1);
      checkOutput({v.name, " no redirect_valid"}, 32'(redirect_valid), 32'd0);
      checkOutput({v.name, " no flush"}, 32'(flush), 32'd0);
      checkOutput({v.name, " rd_write pulse end"}, 32'(rd_write), 32'd0);
      checkOutput({v.name, " misalign pulse end"}, 32'(misalign), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string name);
    checkOutput({name, " op_ready"}, 32'(op_ready), 32'd0);
    checkOutput({name, " busy"}, 32'(busy), 32'd0);
    checkOutput({name, " rd_write"}, 32'(rd_write), 32'd0);
    checkOutput({name, " rd_value"}, rd_value, 32'd0);
    checkOutput({name, " redirect_valid"}, 32'(redirect_valid), 32'd0);
    checkOutput({name, " redirect_pc"}, redirect_pc, 32'd0);
    checkOutput({name, " flush"}, 32'(flush), 32'd0);
    checkOutput({name, " misalign"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    vec_t rv;
    reset = 1'b1; op_valid = 1'b0; op_kind = 2'd0; funct3 = 3'd0; pc = '0;
    rs1_value = '0; rs2_value = '0; immediate = '0; redirect_ready = 1'b0;

    vecs.push_back(mk("jal",       2'd0, 3'd0, 32'h100, 32'h0, 32'h0, 32'h20, 0, 1, 32'h104, 1, 32'h120, 0));
    vecs.push_back(mk("jalr",      2'd1, 3'd0, 32'h300, 32'h2001, 32'h0, 32'h4, 0, 1, 32'h304, 1, 32'h2004, 0));
    vecs.push_back(mk("beq_nt",    2'd2, 3'd0, 32'h200, 32'd5, 32'd6, 32'h10, 0, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk("blt_t",     2'd2, 3'd4, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 0, 32'h0, 1, 32'h440, 0));
    vecs.push_back(mk("bltu_nt",   2'd2, 3'd6, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk("beq_stall", 2'd2, 3'd0, 32'h500, 32'd7, 32'd7, 32'hFFFF_FFF0, 4, 0, 32'h0, 1, 32'h4F0, 0));
    vecs.push_back(mk("bne_t",     2'd2, 3'd1, 32'h600, 32'd1, 32'd2, 32'h8, 0, 0, 32'h0, 1, 32'h608, 0));
    vecs.push_back(mk("bge_t",     2'd2, 3'd5, 32'h700, 32'd1, 32'hFFFF_FFFF, 32'hC, 0, 0, 32'h0, 1, 32'h70C, 0));
    vecs.push_back(mk("bgeu_nt",   2'd2, 3'd7, 32'h700, 32'd1, 32'hFFFF_FFFF, 32'hC, 0, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk("f3_2_nt",   2'd2, 3'd2, 32'h800, 32'd3, 32'd3, 32'h4, 0, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk("reserved",  2'd3, 3'd0, 32'h900, 32'd3, 32'd3, 32'h4, 0, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk("jal_wrap",  2'd0, 3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, 0, 1, 32'h0, 1, 32'h4, 0));
    vecs.push_back(mk("jal_mis",   2'd0, 3'd0, 32'h100, 32'h0, 32'h0, 32'h2, 0, !TRAP, 32'h104, !TRAP, 32'h102, TRAP));
    vecs.push_back(mk("jalr_mis",  2'd1, 3'd0, 32'hA00, 32'h2003, 32'h0, 32'h0, 2, !TRAP, 32'hA04, !TRAP, 32'h2002, TRAP));

    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post-reset op_ready", 32'(op_ready), 32'd1);

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Reset during FLUSH discards the rest of the flush window.
    op_valid = 1'b1; op_kind = 2'd0; pc = 32'h100; immediate = 32'h20; redirect_ready = 1'b1;
    @(negedge clock);
    op_valid = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("mid-flush flush", 32'(flush), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("reset in flush");
    reset = 1'b0;
    @(negedge clock);
    checkOutput("after flush reset op_ready", 32'(op_ready), 32'd1);
    checkOutput("after flush reset flush", 32'(flush), 32'd0);

    // Reset while a redirect is pending drops the redirect entirely.
    op_valid = 1'b1; op_kind = 2'd0; pc = 32'h180; immediate = 32'h40; redirect_ready = 1'b0;
    @(negedge clock);
    op_valid = 1'b0;
    @(negedge clock);
    checkOutput("pending redirect_valid", 32'(redirect_valid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("reset in redirect");
    reset = 1'b0;
    redirect_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("discarded redirect_valid", 32'(redirect_valid), 32'd0);
      checkOutput("discarded flush", 32'(flush), 32'd0);
    end
    redirect_ready = 1'b0;

    for (int n = 0; n < 60; n++) begin
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] im;
      r1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r2 = ($urandom_range(0, 2) == 0) ? r1 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      im = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      rv = ref_model("rand", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                     $urandom & 32'hFFFF_FFFC, r1, r2, im, int'($urandom_range(0, 3)));
      applyStimulus(rv);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
